// File: rtl/aes_spi_scheduler_if.sv
// rtl/aes_spi_scheduler_if.sv - client-side request/result bus of the AES SPI scheduler
interface aes_spi_scheduler_if #(
  parameter int NK = 4
);
  logic              req_enc;
  logic [0:127]      enc_data;
  logic [0:NK*32-1]  enc_key;
  logic              req_dec;
  logic [0:127]      dec_data;
  logic [0:NK*32-1]  dec_key;
  logic              ack_enc;
  logic              ack_dec;
  logic [127:0]      data_out;
  logic              done_out_Enc;
  logic              done_out_Dec;
  logic              busy;

  // Requester side: raises requests and operands, observes acks and results
  modport master (
    output req_enc, enc_data, enc_key, req_dec, dec_data, dec_key,
    input  ack_enc, ack_dec, data_out, done_out_Enc, done_out_Dec, busy
  );

  // Scheduler side
  modport slave (
    input  req_enc, enc_data, enc_key, req_dec, dec_data, dec_key,
    output ack_enc, ack_dec, data_out, done_out_Enc, done_out_Dec, busy
  );
endinterface

// File: rtl/aes_spi_scheduler.sv
// rtl/aes_spi_scheduler.sv - round-robin scheduler and SPI framer for shared AES encrypt/decrypt slaves
module aes_spi_scheduler #(
  parameter int Nk  = 4,
  parameter int Nr  = 10,
  parameter int GAP = 4
) (
  input  logic clk,
  input  logic rst,
  aes_spi_scheduler_if.slave bus,
  output logic MOSI,
  output logic CS_enc,
  output logic CS_dec,
  input  logic MISO_Enc,
  input  logic MISO_Dec
);
  localparam int KEY_W   = Nk * 32;
  localparam int FRAME_W = 128 + KEY_W;
  localparam int CW      = 16;

  localparam logic [CW-1:0] LAST_DATA = CW'(127);
  localparam logic [CW-1:0] LAST_KEY  = CW'(KEY_W - 1);
  localparam logic [CW-1:0] LAST_GAP  = CW'(GAP - 1);
  localparam logic [CW-1:0] LAST_RECV = CW'(127);

  // Nr only configures the slaves; it is checked here so a bad set fails at elaboration.
  if (GAP < 1 || !(Nk == 4 || Nk == 6 || Nk == 8) || !(Nr == 10 || Nr == 12 || Nr == 14)) begin : g_bad_param
    $error("aes_spi_scheduler: unsupported Nk/Nr/GAP combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_DATA, S_SEND_KEY, S_GAP, S_RECV, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [0:FRAME_W-1]   frame_q, frame_d;
  logic                 sel_q, sel_d;             // 1 = decrypt job in flight
  logic                 last_dec_q, last_dec_d;   // 1 = last grant went to decrypt
  logic                 mosi_q, mosi_d;
  logic                 cs_enc_q, cs_enc_d;
  logic                 cs_dec_q, cs_dec_d;
  logic [127:0]         dout_q, dout_d;
  logic                 ack_enc_q, ack_enc_d;
  logic                 ack_dec_q, ack_dec_d;
  logic                 done_enc_q, done_enc_d;
  logic                 done_dec_q, done_dec_d;
  logic                 busy_q, busy_d;

  logic                 grant_enc, grant_dec;
  logic [0:FRAME_W-1]   sel_frame;

  // Next-state and registered-output computation for the frame sequencer
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    frame_d    = frame_q;
    sel_d      = sel_q;
    last_dec_d = last_dec_q;
    mosi_d     = 1'b0;
    cs_enc_d   = cs_enc_q;
    cs_dec_d   = cs_dec_q;
    dout_d     = dout_q;
    ack_enc_d  = 1'b0;
    ack_dec_d  = 1'b0;
    done_enc_d = 1'b0;
    done_dec_d = 1'b0;

    // Round-robin: on a tie the side that did not win last time goes first.
    grant_enc = bus.req_enc && (!bus.req_dec || last_dec_q);
    grant_dec = bus.req_dec && !grant_enc;
    sel_frame = grant_dec ? {bus.dec_data, bus.dec_key} : {bus.enc_data, bus.enc_key};

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (grant_enc || grant_dec) begin
          state_d    = S_SEND_DATA;
          sel_d      = grant_dec;
          last_dec_d = grant_dec;
          // Bit 0 goes out immediately; the shadow register keeps the rest.
          mosi_d     = sel_frame[0];
          frame_d    = sel_frame << 1;
          ack_enc_d  = grant_enc;
          ack_dec_d  = grant_dec;
          cs_enc_d   = !grant_enc;
          cs_dec_d   = !grant_dec;
        end
      end
      S_SEND_DATA: begin
        mosi_d  = frame_q[0];
        frame_d = frame_q << 1;
        if (cnt_q == LAST_DATA) begin
          state_d = S_SEND_KEY;
          cnt_d   = '0;
        end
      end
      S_SEND_KEY: begin
        frame_d = frame_q << 1;
        if (cnt_q == LAST_KEY) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          mosi_d = frame_q[0];
        end
      end
      S_GAP: begin
        if (cnt_q == LAST_GAP) begin
          state_d = S_RECV;
          cnt_d   = '0;
        end
      end
      S_RECV: begin
        dout_d = {dout_q[126:0], sel_q ? MISO_Dec : MISO_Enc};
        if (cnt_q == LAST_RECV) begin
          state_d    = S_DONE;
          cnt_d      = '0;
          cs_enc_d   = 1'b1;
          cs_dec_d   = 1'b1;
          done_enc_d = !sel_q;
          done_dec_d = sel_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        cs_enc_d = 1'b1;
        cs_dec_d = 1'b1;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any frame in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      frame_q    <= '0;
      sel_q      <= 1'b0;
      last_dec_q <= 1'b1;
      mosi_q     <= 1'b0;
      cs_enc_q   <= 1'b1;
      cs_dec_q   <= 1'b1;
      dout_q     <= '0;
      ack_enc_q  <= 1'b0;
      ack_dec_q  <= 1'b0;
      done_enc_q <= 1'b0;
      done_dec_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      sel_q      <= sel_d;
      last_dec_q <= last_dec_d;
      mosi_q     <= mosi_d;
      cs_enc_q   <= cs_enc_d;
      cs_dec_q   <= cs_dec_d;
      dout_q     <= dout_d;
      ack_enc_q  <= ack_enc_d;
      ack_dec_q  <= ack_dec_d;
      done_enc_q <= done_enc_d;
      done_dec_q <= done_dec_d;
      busy_q     <= busy_d;
    end
  end

  assign MOSI             = mosi_q;
  assign CS_enc           = cs_enc_q;
  assign CS_dec           = cs_dec_q;
  assign bus.ack_enc      = ack_enc_q;
  assign bus.ack_dec      = ack_dec_q;
  assign bus.data_out     = dout_q;
  assign bus.done_out_Enc = done_enc_q;
  assign bus.done_out_Dec = done_dec_q;
  assign bus.busy         = busy_q;
endmodule

// File: doc/aes_spi_scheduler.md
Name: aes_spi_scheduler

Overview:
Front-end controller that shares the serial AES engines between two clients: an encrypt requester and a decrypt requester. It arbitrates between pending requests using round-robin and owns the SPI frame. For each job it drives the chip select of the chosen slave, shifts data then key out on MOSI, waits a fixed turnaround, and shifts the 128-bit result in from that slave's MISO. It sits between the system bus side and the encrypt/decrypt SPI slaves, and replaces ad-hoc master sequencing with a handshaked, single-clock-edge FSM.

Parameters:
Nk, 4, key length in 32-bit words (4/6/8); key frame is Nk*32 bits.
Nr, 10, round count; passed through for slave configuration only, with no logic effect here.
GAP, 4, turnaround cycles between the last key bit and the first response bit (MOSI=0 during the gap); must be at least 1.

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous active-high reset
req_enc  in  1  encrypt request (level); held until ack_enc
enc_data  in  [0:127]  encrypt plaintext; bit 0 is sent first
enc_key  in  [0:Nk*32-1]  encrypt key; bit 0 is sent first
req_dec  in  1  decrypt request (level); held until ack_dec
dec_data  in  [0:127]  decrypt ciphertext
dec_key  in  [0:Nk*32-1]  decrypt key
ack_enc  out  1  one-cycle pulse: encrypt job accepted, operands latched
ack_dec  out  1  one-cycle pulse: decrypt job accepted
MOSI  out  1  serial data to both slaves (registered)
CS_enc  out  1  encrypt slave select, active low
CS_dec  out  1  decrypt slave select, active low
MISO_Enc  in  1  serial result from encrypt slave
MISO_Dec  in  1  serial result from decrypt slave
data_out  out  [127:0]  received result
done_out_Enc  out  1  one-cycle pulse: encrypt result valid on data_out
done_out_Dec  out  1  one-cycle pulse: decrypt result valid on data_out
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (takes priority over all other inputs, in any state):
  - state IDLE; MOSI=0; CS_enc=CS_dec=1; data_out=0.
  - ack_*, done_*, busy = 0; all counters 0.
  - last_grant=DEC, so ENC wins the first tie.
- FSM states: IDLE, SEND_DATA, SEND_KEY, GAP, RECV, DONE. One counter, reloaded on each state entry.
- IDLE arbitration:
  - Only req_enc high → ENC. Only req_dec high → DEC.
  - Both high → the side not equal to last_grant.
  - Neither high → stay in IDLE.
- At the granting edge:
  - Latch the selected data and key into shadow registers; set sel; update last_grant.
  - Go to SEND_DATA. Assert ack_sel for exactly the next cycle.
  - The selected CS goes low in that same cycle; the other CS stays 1.
- SEND_DATA: 128 cycles. In cycle k (k=0..127), MOSI = data[k].
- SEND_KEY: Nk*32 cycles. In cycle k, MOSI = key[k].
- GAP: GAP cycles with MOSI=0.
- RECV: 128 cycles, MOSI=0.
  - Each edge samples the selected MISO: data_out <= {data_out[126:0], MISO_sel}.
  - The first received bit ends at data_out[127].
  - The unselected MISO is ignored.
- DONE: 1 cycle.
  - Both CS = 1; done_out_sel = 1.
  - data_out holds the result and keeps holding it until the next RECV begins shifting.
  - Next state is IDLE.
- Latency: with the granting edge as E0, done is high in cycle 128 + Nk*32 + GAP + 128 + 1 after E0 (389 for the defaults).
  - Minimum grant-to-grant spacing is that value + 1 (mandatory IDLE cycle).
- Requests:
  - Requests arriving while busy wait; they are evaluated only in IDLE.
  - A request dropped before its ack is lost, with no error.
  - Input operand changes after ack have no effect.
- Chip selects: CS_enc and CS_dec are never low at the same time. Both are high in IDLE and DONE.
- Reset mid-frame: the frame is aborted immediately. CS returns high on the next cycle and no done pulse is produced. The slaves resynchronise on CS high.
- ack_* and done_* are never high together. Only one of each pair is high in any cycle.

Test Plan:
- Single encrypt: req_enc=1, enc_data=128'h00112233445566778899aabbccddeeff, key=128'h000102030405060708090a0b0c0d0e0f; slave model returns 128'h69c4e0d86a7b0430d8cdb78070b4c55a → ack_enc one cycle after grant; MOSI bit stream equals data then key; done_out_Enc at cycle 389; data_out=69c4e0d8...c55a; CS_dec stays 1 throughout.
- Single decrypt: same vector reversed on the decrypt side → done_out_Dec, data_out=00112233...eeff; CS_enc stays 1.
- Simultaneous requests held high continuously after reset → grant order ENC, DEC, ENC, DEC; each done precedes the next ack by ≥2 cycles; the CS lines never overlap.
- Reset mid-frame: assert rst during SEND_KEY cycle 50 → next cycle CS_enc=1, MOSI=0, data_out=0, no done; a new req_enc afterwards completes normally.
- Nk=8, GAP=2: single encrypt → SEND_KEY lasts 256 cycles; done at cycle 128+256+2+128+1=515; result correct.
- Request withdrawn: pulse req_dec for 1 cycle while busy → it is never acked; busy drops after the current job's DONE.
